wb_display_queue: RTL and testbench
===================================

// Module: wb_display_queue
// PURPOSE
//  Buffers 32-bit CPU writeback values between RV_CPU and the SevenSegDisplay scanner.
//  Paces the values so each one stays on the 8-digit display for a visible dwell time.
//  Outputs eight 4-bit hex digits and a per-digit blank mask, in the format the scanner consumes.
//  Writes that arrive while the queue is full are dropped and counted.
// PARAMETERS
//  DEPTH         4            queue entries, power of 2, >=2
//  DWELL_CYCLES  100_000_000  minimum clk cycles a value is shown (>=1); 1 s at 100 MHz
// PORTS
//  clk          in   1            system clock, all logic posedge
//  rst          in   1            async active-high reset
//  wb_valid     in   1            writeback value present this cycle
//  wb_data      in   32           writeback value
//  wb_ready     out  1            queue not full; combinational = !full
//  digit        out  [7:0][3:0]   digit[i] = shown_value[4i+3:4i], i.e. digit[7] is the MS nibble
//  digit_blank  out  8            1 = scanner blanks digit i
//  disp_valid   out  1            a captured value is on display
//  occupancy    out  $clog2(DEPTH+1)  entries queued, not counting the shown value
//  drop_count   out  8            saturating count of rejected writes
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high.
//   - digit = all 4'hF, digit_blank = 8'hFF, disp_valid = 0.
//   - occupancy = 0, drop_count = 0, state = IDLE, dwell counter = 0.
//   - Queue contents are discarded.
//   - Reset mid-dwell or mid-burst takes effect immediately; there is no drain.
//  Push:
//   - Accept on a rising edge with wb_valid & !full.
//   - wb_valid & full: value discarded; drop_count += 1, saturating at 255.
//   - A pop in the same cycle does NOT free space for that cycle's push.
//   - There is no push-to-display bypass.
//  FSM: IDLE / SHOW / HOLD
//   - IDLE: when occupancy>0, pop the head and register it into the digits.
//     Set disp_valid=1, clear the dwell counter, go to SHOW.
//   - SHOW: the counter increments each cycle. At count == DWELL_CYCLES-1:
//     - occupancy>0: pop the next entry, load it, clear the counter, stay in SHOW.
//     - else: go to HOLD.
//   - HOLD: the last value is held indefinitely.
//     When occupancy>0, pop and load next cycle, clear the counter, go to SHOW.
//   - The FSM never returns to IDLE except on reset.
//  Latency:
//   - Accept at edge N into an empty queue in IDLE or HOLD: pop and digit update at edge N+1.
//   - Each value is visible for at least DWELL_CYCLES cycles, or until reset.
//  Arithmetic:
//   - Dwell counter width is $clog2(DWELL_CYCLES)+1.
//   - Queue pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - full = (occupancy == DEPTH).
//  Simultaneous push+pop with 0<occ<DEPTH: occupancy unchanged, pointers both advance.
//  digit and digit_blank are registered and change on the same edge.
// CONFIGURATION
//  LZB_EN defined:
//   - Leading-zero blanking. digit_blank[i] = 1 for every digit above the most significant nonzero nibble.
//   - digit[0] is never blanked while disp_valid.
//   - Computed from the value being loaded and registered with digit.
//  LZB_EN undefined: digit_blank = 8'h00 whenever disp_valid = 1.
//  Both builds: digit_blank = 8'hFF while disp_valid = 0.
// TESTING (DEPTH=4, DWELL_CYCLES=4)
//  1. Assert rst mid-cycle -> outputs immediately take the reset values: digit all F, blank FF, disp_valid 0, wb_ready 1, occupancy 0, drop_count 0.
//  2. Push 0x1234ABCD once -> one edge later digit[7:0] = 1,2,3,4,A,B,C,D and disp_valid=1; the value is held >20 cycles in HOLD.
//  3. Six back-to-back pushes 0x11..0x66 -> first 5 accepted, 6th dropped: wb_ready=0 at that edge and drop_count=1; display shows 0x11,0x22,0x33,0x44,0x55, each for exactly 4 cycles, then holds 0x55.
//  4. Fill the queue, then hold wb_valid high for 300 cycles with no pops possible (long DWELL override) -> drop_count saturates at 255 and does not wrap.
//  5. LZB_EN: 0x00000A05 -> blank 8'b11111000; 0x00000000 -> 8'b11111110. Without LZB_EN, both -> blank 8'h00.
//  6. rst asserted with occupancy=2 mid-dwell -> all outputs take reset values asynchronously; after release, a new push displays one edge after accept.

Source files
------------

// File: rtl/wb_display_queue.sv
// wb_display_queue: paces 32-bit CPU writeback values onto an 8-digit hex
// display. Values are queued (DEPTH entries), and each one is shown for at
// least DWELL_CYCLES clocks. Writes arriving while the queue is full are
// dropped and counted in a saturating counter.
//
// Optional feature: define LZB_EN for leading-zero blanking of the shown value.
//
// Ports:
//   clk, rst      clock (posedge), async active-high reset
//   wb_valid      writeback value present this cycle
//   wb_data       writeback value
//   wb_ready      combinational !full
//   digit         digit[i] = shown_value[4i+3:4i]
//   digit_blank   per-digit blank mask for the scanner (1 = blank)
//   disp_valid    a captured value is on display
//   occupancy     queued entries, not counting the shown value
//   drop_count    saturating count of rejected writes
module wb_display_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  input  logic [31:0]                  wb_data,
  output logic                         wb_ready,
  output logic [7:0][3:0]              digit,
  output logic [7:0]                   digit_blank,
  output logic                         disp_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [7:0]                   drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [7:0]            drop_q, drop_d;
  logic [7:0][3:0]       digit_q, digit_d;
  logic [7:0]            blank_q, blank_d;
  logic                  disp_valid_q, disp_valid_d;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic [31:0]           head;

  assign full     = (occ_q == OCC_W'(DEPTH));
  assign push     = wb_valid & ~full;
  assign head     = mem_q[rd_ptr_q];
  assign wb_ready = ~full;

`ifdef LZB_EN
  // Blank every digit above the most significant nonzero nibble; digit 0 always shown.
  function automatic logic [7:0] lzb_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       seen;
    m    = 8'h00;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) seen = 1'b1;
      m[i] = ~seen;
    end
    return m;
  endfunction
`endif

  // Display pacing FSM: decides when to pop the head into the digits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (occ_q != '0) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          if (occ_q != '0) begin
            pop   = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (occ_q != '0) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue bookkeeping, drop counter and display registers.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    drop_d       = drop_q;
    digit_d      = digit_q;
    blank_d      = blank_q;
    disp_valid_d = disp_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (wb_valid && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (pop) begin
      digit_d      = head;
      disp_valid_d = 1'b1;
`ifdef LZB_EN
      blank_d      = lzb_mask(head);
`else
      blank_d      = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      drop_q       <= '0;
      digit_q      <= {8{4'hF}};
      blank_q      <= 8'hFF;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      drop_q       <= drop_d;
      digit_q      <= digit_d;
      blank_q      <= blank_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wb_data;
  end

  assign digit       = digit_q;
  assign digit_blank = blank_q;
  assign disp_valid  = disp_valid_q;
  assign occupancy   = occ_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_wb_display_queue.sv
// Randomized and directed bench for wb_display_queue against a queue-based
// reference model. A second instance with a long dwell exercises drop-count
// saturation.
module tb_wb_display_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned LONG_DWELL = 1000;

  logic            clk;
  logic            rst;
  logic            wb_valid;
  logic [31:0]     wb_data;
  logic            wb_ready;
  logic [7:0][3:0] digit;
  logic [7:0]      digit_blank;
  logic            disp_valid;
  logic [2:0]      occupancy;
  logic [7:0]      drop_count;

  logic            wb_valid_s;
  logic [31:0]     wb_data_s;
  logic            wb_ready_s;
  logic [7:0][3:0] digit_s;
  logic [7:0]      digit_blank_s;
  logic            disp_valid_s;
  logic [2:0]      occupancy_s;
  logic [7:0]      drop_count_s;

  wb_display_queue #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_ready(wb_ready), .digit(digit), .digit_blank(digit_blank),
    .disp_valid(disp_valid), .occupancy(occupancy), .drop_count(drop_count)
  );

  wb_display_queue #(.DEPTH(DEPTH), .DWELL_CYCLES(LONG_DWELL)) dut_sat (
    .clk(clk), .rst(rst), .wb_valid(wb_valid_s), .wb_data(wb_data_s),
    .wb_ready(wb_ready_s), .digit(digit_s), .digit_blank(digit_blank_s),
    .disp_valid(disp_valid_s), .occupancy(occupancy_s), .drop_count(drop_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_q[$];
  logic [31:0] m_digit;
  logic [7:0]  m_blank;
  logic        m_valid;
  int          m_shown;
  int          m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_blank(input logic [31:0] v);
`ifdef LZB_EN
    int top;
    top = 0;
    for (int i = 0; i < 8; i++)
      if (((v >> (4 * i)) & 32'hF) != 32'h0) top = i;
    return 8'(8'hFF << (top + 1));
`else
    return (v == v) ? 8'h00 : 8'hFF;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_digit = 32'hFFFF_FFFF;
    m_blank = 8'hFF;
    m_valid = 1'b0;
    m_shown = 0;
    m_drop  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".digit"}, digit, m_digit);
    check({tag, ".blank"}, 32'(digit_blank), 32'(m_blank));
    check({tag, ".valid"}, 32'(disp_valid), 32'(m_valid));
    check({tag, ".occ"},   32'(occupancy), 32'(m_q.size()));
    check({tag, ".drop"},  32'(drop_count), 32'(m_drop));
  endtask

  // One clock: drive inputs, check ready, advance model on the edge, check outputs.
  task automatic step(input string tag, input logic v, input logic [31:0] d);
    bit full;
    bit do_pop;
    wb_valid = v;
    wb_data  = d;
    full   = (m_q.size() == DEPTH);
    check({tag, ".ready"}, 32'(wb_ready), 32'(!full));
    @(posedge clk);
    // A value leaves the queue once the current one has had its dwell.
    do_pop = (m_q.size() > 0) && (!m_valid || m_shown >= int'(DWELL) - 1);
    if (do_pop) begin
      m_digit = m_q.pop_front();
      m_blank = exp_blank(m_digit);
      m_valid = 1'b1;
      m_shown = 0;
    end else if (m_valid && m_shown < 1000000) begin
      m_shown++;
    end
    if (v) begin
      if (!full) m_q.push_back(d);
      else if (m_drop < 255) m_drop++;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".digit"}, digit, 32'hFFFF_FFFF);
    check({tag, ".blank"}, 32'(digit_blank), 32'hFF);
    check({tag, ".valid"}, 32'(disp_valid), 32'h0);
    check({tag, ".ready"}, 32'(wb_ready), 32'h1);
    check({tag, ".occ"},   32'(occupancy), 32'h0);
    check({tag, ".drop"},  32'(drop_count), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    rst        = 1'b0;
    wb_valid   = 1'b0;
    wb_data    = 32'h0;
    wb_valid_s = 1'b0;
    wb_data_s  = 32'h0;
    model_reset();

    // 1: asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_values("t1_async");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("t1_release");

    // 2: single push, one-edge latency, then held in HOLD
    step("t2_push", 1'b1, 32'h1234_ABCD);
    step("t2_load", 1'b0, 32'h0);
    check("t2_digit", digit, 32'h1234_ABCD);
    check("t2_valid", 32'(disp_valid), 32'h1);
    for (int i = 0; i < 22; i++) step("t2_hold", 1'b0, 32'h0);
    check("t2_held", digit, 32'h1234_ABCD);

    // 3: six back-to-back pushes, sixth dropped, paced display
    do_reset();
    for (int i = 1; i <= 6; i++) step("t3_burst", 1'b1, 32'(i * 32'h11));
    check("t3_drop", 32'(drop_count), 32'h1);
    for (int i = 0; i < 30; i++) step("t3_drain", 1'b0, 32'h0);
    check("t3_last", digit, 32'h55);

    // 4: drop counter saturation with a long-dwell instance
    do_reset();
    wb_valid_s = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      wb_data_s = 32'(k);
      @(posedge clk);
      #1;
      if (k == 100) check("t4_drop100", 32'(drop_count_s), 32'd95);
    end
    check("t4_sat", 32'(drop_count_s), 32'd255);
    check("t4_ready", 32'(wb_ready_s), 32'h0);
    check("t4_occ", 32'(occupancy_s), 32'd4);
    wb_valid_s = 1'b0;

    // 5: blanking of small values
    do_reset();
    step("t5_push_a05", 1'b1, 32'h0000_0A05);
    step("t5_load_a05", 1'b0, 32'h0);
`ifdef LZB_EN
    check("t5_blank_a05", 32'(digit_blank), 32'h0000_00F8);
`else
    check("t5_blank_a05", 32'(digit_blank), 32'h0);
`endif
    for (int i = 0; i < 5; i++) step("t5_wait", 1'b0, 32'h0);
    step("t5_push_zero", 1'b1, 32'h0);
    step("t5_load_zero", 1'b0, 32'h0);
    check("t5_digit_zero", digit, 32'h0);
`ifdef LZB_EN
    check("t5_blank_zero", 32'(digit_blank), 32'h0000_00FE);
`else
    check("t5_blank_zero", 32'(digit_blank), 32'h0);
`endif

    // 6: reset with occupancy 2 mid-dwell, then fresh push
    do_reset();
    step("t6_fill", 1'b1, 32'hA);
    step("t6_fill", 1'b1, 32'hB);
    step("t6_fill", 1'b1, 32'hC);
    step("t6_mid", 1'b0, 32'h0);
    check("t6_occ2", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1 check_reset_values("t6_async");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    step("t6_push", 1'b1, 32'hCAFE_0001);
    step("t6_load", 1'b0, 32'h0);
    check("t6_digit", digit, 32'hCAFE_0001);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      step("rand", ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 20)), d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
